// File: rtl/alien_grid_stat.sv
// Alien grid bookkeeping: tracks which aliens are alive, scores kills, and times
// the explosion shown after each kill. All outputs come straight from flops.
module alien_grid_stat #(
    parameter int ROWS           = 3,
    parameter int COLS           = 7,
    parameter int BASE_PTS       = 10,
    parameter int EXPLODE_FRAMES = 8,
    parameter int SCORE_W        = 16,
    localparam int N  = ROWS * COLS,
    localparam int IW = (N > 1) ? $clog2(N) : 1,
    localparam int CW = $clog2(N + 1)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [N-1:0]       hit,
    input  logic [2:0]         curr_state,
    input  logic               frame_tick,
    output logic [N-1:0]       alive,
    output logic               exploding,
    output logic [IW-1:0]      explode_idx,
    output logic               point,
    output logic [SCORE_W-1:0] score,
    output logic [CW-1:0]      alive_count,
    output logic               cleared
);

    typedef enum logic {IDLE = 1'b0, EXPLODE = 1'b1} state_t;

    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    logic          grid_clr;
    logic          kill;
    logic [IW-1:0] k;
    logic [31:0]   pts;
    logic [SCORE_W+32:0] sum;

    assign grid_clr = (curr_state == 3'd0) || (curr_state == 3'd5) || (curr_state == 3'd6);

    // Ascending scan so the last match, i.e. the highest live index, wins.
    always_comb begin
        kill = 1'b0;
        k    = '0;
        pts  = '0;
        for (int i = 0; i < N; i++) begin
            if (hit[i] && alive[i]) begin
                kill = 1'b1;
                k    = i[IW-1:0];
                pts  = 32'(BASE_PTS * (ROWS - i / COLS));
            end
        end
    end

    // Wide enough that the add can never wrap before saturation is applied.
    assign sum = {33'd0, score} + (SCORE_W + 33)'(pts);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (grid_clr) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
        end else if (kill) begin
            state_d = EXPLODE;
            cnt_d   = 8'(EXPLODE_FRAMES);
        end else if (state_q == EXPLODE && frame_tick) begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1)
                state_d = IDLE;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign exploding = (state_q == EXPLODE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            alive       <= '1;
            alive_count <= CW'(N);
            score       <= '0;
            point       <= 1'b0;
            explode_idx <= '0;
            cleared     <= 1'b0;
        end else if (grid_clr) begin
            alive       <= '1;
            alive_count <= CW'(N);
            point       <= 1'b0;
            cleared     <= 1'b0;
            if (curr_state == 3'd0)
                score <= '0;
        end else begin
            point   <= kill;
            // Once empty and idle nothing can revive an alien short of a grid clear.
            cleared <= cleared | ((alive_count == '0) && (state_q == IDLE));
            if (kill) begin
                alive[k]    <= 1'b0;
                alive_count <= alive_count - CW'(1);
                explode_idx <= k;
                score       <= (sum > (SCORE_W + 33)'(SCORE_MAX)) ? SCORE_MAX : sum[SCORE_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_alien_grid_stat.sv
// Randomized and directed bench for alien_grid_stat, checked against a cycle-level
// model built from the game rules (default grid plus a 6-bit-score instance).
module tb_alien_grid_stat;
    localparam int ROWS = 3;
    localparam int COLS = 7;
    localparam int N    = ROWS * COLS;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [N-1:0]  hit;
    logic [2:0]    curr_state;
    logic          frame_tick;

    logic [N-1:0]  alive, alive6;
    logic          exploding, exploding6;
    logic [4:0]    explode_idx, explode_idx6;
    logic          point, point6;
    logic [15:0]   score;
    logic [5:0]    score6;
    logic [4:0]    alive_count, alive_count6;
    logic          cleared, cleared6;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit [N-1:0] m_alive;
    int  m_score, m_score6, m_rem, m_idx;
    bit  m_expl, m_point, m_cleared;

    alive_grid_dummy_guard u_guard ();

    alien_grid_stat u_dut (
        .Clk(Clk), .Reset(Reset), .hit(hit), .curr_state(curr_state), .frame_tick(frame_tick),
        .alive(alive), .exploding(exploding), .explode_idx(explode_idx), .point(point),
        .score(score), .alive_count(alive_count), .cleared(cleared)
    );

    alien_grid_stat #(.SCORE_W(6)) u_sat (
        .Clk(Clk), .Reset(Reset), .hit(hit), .curr_state(curr_state), .frame_tick(frame_tick),
        .alive(alive6), .exploding(exploding6), .explode_idx(explode_idx6), .point(point6),
        .score(score6), .alive_count(alive_count6), .cleared(cleared6)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [N-1:0] h, input logic [2:0] st, input logic ft, input logic rst);
        int k;
        if (rst) begin
            m_alive = '1; m_score = 0; m_score6 = 0; m_point = 0;
            m_expl = 0; m_idx = 0; m_rem = 0; m_cleared = 0;
        end else if (st == 0 || st == 5 || st == 6) begin
            m_alive = '1; m_point = 0; m_expl = 0; m_rem = 0; m_cleared = 0;
            if (st == 0) begin m_score = 0; m_score6 = 0; end
        end else begin
            if ($countones(m_alive) == 0 && !m_expl) m_cleared = 1;
            k = -1;
            for (int i = N - 1; i >= 0; i--)
                if (k < 0 && h[i] && m_alive[i]) k = i;
            if (k >= 0) begin
                m_alive[k] = 0;
                m_score  = (m_score  + 10 * (ROWS - k / COLS) > 65535) ? 65535 : m_score  + 10 * (ROWS - k / COLS);
                m_score6 = (m_score6 + 10 * (ROWS - k / COLS) > 63)    ? 63    : m_score6 + 10 * (ROWS - k / COLS);
                m_expl = 1; m_idx = k; m_rem = 8; m_point = 1;
            end else begin
                m_point = 0;
                if (m_expl && ft) begin
                    m_rem--;
                    if (m_rem == 0) m_expl = 0;
                end
            end
        end
    endtask

    task automatic step(input logic [N-1:0] h, input logic [2:0] st, input logic ft, input logic rst);
        hit = h; curr_state = st; frame_tick = ft; Reset = rst;
        model(h, st, ft, rst);
        @(posedge Clk);
        #1;
        chk("alive",       32'(alive),       32'(m_alive));
        chk("alive_count", 32'(alive_count), 32'($countones(m_alive)));
        chk("score",       32'(score),       32'(m_score));
        chk("score6",      32'(score6),      32'(m_score6));
        chk("point",       32'(point),       32'(m_point));
        chk("exploding",   32'(exploding),   32'(m_expl));
        chk("explode_idx", 32'(explode_idx), 32'(m_idx));
        chk("cleared",     32'(cleared),     32'(m_cleared));
    endtask

    function automatic logic [N-1:0] bitv(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    initial begin
        logic [N-1:0] h;
        logic [2:0]   st;
        int           sel;

        step('0, 3'd1, 1'b0, 1'b1);
        step('0, 3'd1, 1'b0, 1'b1);

        // single bottom-row kill
        step(bitv(20), 3'd1, 1'b0, 1'b0);
        chk("single_score", 32'(score), 32'd10);
        chk("single_idx",   32'(explode_idx), 32'd20);
        step('0, 3'd1, 1'b0, 1'b0);
        chk("single_point_drop", 32'(point), 32'd0);

        // multi-hit, then dead hit
        step(bitv(3) | bitv(0), 3'd2, 1'b0, 1'b0);
        chk("multi_score", 32'(score), 32'd40);
        step(bitv(3), 3'd2, 1'b0, 1'b0);
        chk("dead_point", 32'(point), 32'd0);

        // explosion: 4 ticks, re-kill (with a simultaneous tick), 8 more ticks
        for (int i = 0; i < 4; i++) step('0, 3'd3, 1'b1, 1'b0);
        step(bitv(10), 3'd3, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step('0, 3'd3, 1'b1, 1'b0);
        chk("explode_done", 32'(exploding), 32'd0);
        step('0, 3'd3, 1'b1, 1'b0);

        // clear the wave from a fresh grid
        step('0, 3'd0, 1'b0, 1'b0);
        for (int i = N - 1; i >= 0; i--) step(bitv(i), 3'd4, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step('0, 3'd4, 1'b1, 1'b0);
        step('0, 3'd4, 1'b0, 1'b0);
        chk("wave_score",   32'(score), 32'd420);
        chk("wave_cleared", 32'(cleared), 32'd1);
        step('0, 3'd7, 1'b1, 1'b0);

        step('0, 3'd5, 1'b0, 1'b0);
        chk("st5_score", 32'(score), 32'd420);
        step('0, 3'd0, 1'b0, 1'b0);

        // saturation on the 6-bit instance
        for (int i = 0; i < 3; i++) step(bitv(i), 3'd1, 1'b0, 1'b0);
        chk("sat_score6", 32'(score6), 32'd63);

        // reset mid-kill during an explosion
        step(bitv(15), 3'd1, 1'b0, 1'b1);
        step('0, 3'd1, 1'b0, 1'b0);

        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 29);
            if (sel == 0) st = 3'd0;
            else if (sel == 1) st = 3'd5;
            else if (sel == 2) st = 3'd6;
            else begin
                st = 3'($urandom_range(1, 5));
                if (st == 3'd5) st = 3'd7;
            end
            h = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom & $urandom & $urandom);
            step(h, st, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

module alive_grid_dummy_guard;
endmodule
